// File: rtl/frame_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_cfg_pkg
// Description : Shared FSM encoding, width helpers and strobe index mapping
//               for the configuration frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_cfg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_SETUP  = 2'd1;
    localparam state_t c_ST_STROBE = 2'd2;
    localparam state_t c_ST_HOLD   = 2'd3;

    localparam int c_DEF_FRAME_BITS = 32;
    localparam int c_DEF_FRAMES     = 20;
    localparam int c_DEF_COLUMNS    = 4;

    // Index width that never collapses to zero bits for a count of 1.
    function automatic int f_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int f_col_w(input int num_columns);
        return f_width(num_columns);
    endfunction

    function automatic int f_frame_w(input int frames_per_col);
        return f_width(frames_per_col);
    endfunction

    function automatic int f_strobe_w(input int num_columns, input int frames_per_col);
        return num_columns * frames_per_col;
    endfunction

    function automatic int f_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int f_strobe_index(input int col, input int frame, input int frames_per_col);
        return col * frames_per_col + frame;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_cfg_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_cfg_phase_timer
// Description : Loadable down-counter; expires while the count sits at 1.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_cfg_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_load) begin
            w_count_d = i_load_val;
        end else if (r_count_q > CNT_W'(1)) begin
            w_count_d = r_count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_expire = (r_count_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/frame_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frame_config_sequencer
// Description : Drives FrameData/FrameStrobe with setup/pulse/hold windows for
//               single frame writes and for a full zeroing sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_config_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int FRAME_BITS_PER_ROW = c_DEF_FRAME_BITS,
    parameter int MAX_FRAMES_PER_COL = c_DEF_FRAMES,
    parameter int NUM_COLUMNS        = c_DEF_COLUMNS,
    parameter int SETUP_CYCLES       = 1,
    parameter int STROBE_CYCLES      = 2,
    parameter int HOLD_CYCLES        = 1,
    localparam int c_COL_W    = f_col_w(NUM_COLUMNS),
    localparam int c_FRAME_W  = f_frame_w(MAX_FRAMES_PER_COL),
    localparam int c_STROBE_W = f_strobe_w(NUM_COLUMNS, MAX_FRAMES_PER_COL)
) (
    input  logic                          UserCLK,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [c_COL_W-1:0]            req_col,
    input  logic [c_FRAME_W-1:0]          req_frame,
    input  logic [FRAME_BITS_PER_ROW-1:0] req_data,
    input  logic                          clear_start,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [FRAME_BITS_PER_ROW-1:0] FrameData,
    output logic [c_STROBE_W-1:0]         FrameStrobe
);

    localparam int c_CNT_W = f_width(f_max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES) + 1);

    localparam logic [c_CNT_W-1:0]   c_LOAD_SETUP  = c_CNT_W'(SETUP_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_LOAD_STROBE = c_CNT_W'(STROBE_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_LOAD_HOLD   = c_CNT_W'(HOLD_CYCLES);
    localparam logic [c_COL_W-1:0]   c_COL_LAST    = c_COL_W'(NUM_COLUMNS - 1);
    localparam logic [c_FRAME_W-1:0] c_FRAME_LAST  = c_FRAME_W'(MAX_FRAMES_PER_COL - 1);
    localparam logic [c_COL_W:0]     c_COL_LIMIT   = (c_COL_W + 1)'(NUM_COLUMNS);
    localparam logic [c_FRAME_W:0]   c_FRAME_LIMIT = (c_FRAME_W + 1)'(MAX_FRAMES_PER_COL);

    generate
        if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1 ||
            NUM_COLUMNS < 1 || MAX_FRAMES_PER_COL < 1 || FRAME_BITS_PER_ROW < 1) begin : g_bad_params
            $error("frame_config_sequencer: phase lengths and sizes must all be at least 1");
        end
    endgenerate

    state_t                        r_state_q, w_state_d;
    logic [c_COL_W-1:0]            r_col_q,   w_col_d;
    logic [c_FRAME_W-1:0]          r_frame_q, w_frame_d;
    logic [FRAME_BITS_PER_ROW-1:0] r_data_q,  w_data_d;
    logic                          r_clear_q, w_clear_d;
    logic                          r_err_q,   w_err_d;

    logic                          w_load;
    logic [c_CNT_W-1:0]            w_load_val;
    logic                          w_expire;
    logic                          w_out_of_range;
    logic                          w_last_index;
    int                            w_strobe_idx;

    frame_cfg_phase_timer #(
        .CNT_W (c_CNT_W)
    ) u_phase_timer (
        .clk        (UserCLK),
        .rst        (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    assign w_out_of_range = ({1'b0, req_col} >= c_COL_LIMIT) ||
                            ({1'b0, req_frame} >= c_FRAME_LIMIT);
    assign w_last_index   = (r_col_q == c_COL_LAST) && (r_frame_q == c_FRAME_LAST);

    always_comb begin
        w_state_d  = r_state_q;
        w_col_d    = r_col_q;
        w_frame_d  = r_frame_q;
        w_data_d   = r_data_q;
        w_clear_d  = r_clear_q;
        w_err_d    = 1'b0;
        w_load     = 1'b0;
        w_load_val = c_LOAD_SETUP;

        case (r_state_q)
            c_ST_IDLE: begin
                // A clear request pre-empts any request presented in the same cycle.
                if (clear_start) begin
                    w_state_d  = c_ST_SETUP;
                    w_col_d    = '0;
                    w_frame_d  = '0;
                    w_data_d   = '0;
                    w_clear_d  = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = c_LOAD_SETUP;
                end else if (req_valid) begin
                    if (w_out_of_range) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_state_d  = c_ST_SETUP;
                        w_col_d    = req_col;
                        w_frame_d  = req_frame;
                        w_data_d   = req_data;
                        w_clear_d  = 1'b0;
                        w_load     = 1'b1;
                        w_load_val = c_LOAD_SETUP;
                    end
                end
            end
            c_ST_SETUP: begin
                if (w_expire) begin
                    w_state_d  = c_ST_STROBE;
                    w_load     = 1'b1;
                    w_load_val = c_LOAD_STROBE;
                end
            end
            c_ST_STROBE: begin
                if (w_expire) begin
                    w_state_d  = c_ST_HOLD;
                    w_load     = 1'b1;
                    w_load_val = c_LOAD_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (w_expire) begin
                    if (r_clear_q && !w_last_index) begin
                        w_state_d  = c_ST_SETUP;
                        w_load     = 1'b1;
                        w_load_val = c_LOAD_SETUP;
                        if (r_frame_q == c_FRAME_LAST) begin
                            w_frame_d = '0;
                            w_col_d   = r_col_q + c_COL_W'(1);
                        end else begin
                            w_frame_d = r_frame_q + c_FRAME_W'(1);
                        end
                    end else begin
                        w_state_d = c_ST_IDLE;
                        w_clear_d = 1'b0;
                    end
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
                w_clear_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge UserCLK) begin
        if (reset) begin
            r_state_q <= c_ST_IDLE;
            r_col_q   <= '0;
            r_frame_q <= '0;
            r_data_q  <= '0;
            r_clear_q <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_col_q   <= w_col_d;
            r_frame_q <= w_frame_d;
            r_data_q  <= w_data_d;
            r_clear_q <= w_clear_d;
            r_err_q   <= w_err_d;
        end
    end

    assign w_strobe_idx = f_strobe_index(int'(r_col_q), int'(r_frame_q), MAX_FRAMES_PER_COL);

    always_comb begin
        FrameStrobe = '0;
        if (r_state_q == c_ST_STROBE) begin
            for (int i = 0; i < c_STROBE_W; i++) begin
                if (w_strobe_idx == i) begin
                    FrameStrobe[i] = 1'b1;
                end
            end
        end
    end

    assign FrameData = r_data_q;
    assign req_ready = (r_state_q == c_ST_IDLE) && !clear_start;
    assign busy      = (r_state_q != c_ST_IDLE);
    assign err       = r_err_q;
    assign done      = (r_state_q == c_ST_HOLD) && w_expire && (!r_clear_q || w_last_index);

endmodule
`default_nettype wire

// File: tb/tb_frame_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_config_sequencer
// Description : Two sequencer instances (default timing and S=3/T=1/H=2) fed
//               the same stimulus and compared against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_config_sequencer;

    localparam int FB = 32;
    localparam int F  = 20;
    localparam int N  = 4;
    localparam int SW = N * F;
    localparam int SV [2] = '{1, 3};
    localparam int TV [2] = '{2, 1};
    localparam int HV [2] = '{1, 2};

    logic          UserCLK = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          clear_start;
    logic [1:0]    req_col;
    logic [4:0]    req_frame;
    logic [FB-1:0] req_data;

    logic          req_ready [2];
    logic          busy [2];
    logic          done [2];
    logic          err [2];
    logic [FB-1:0] frame_data [2];
    logic [SW-1:0] frame_strobe [2];

    int checks = 0;
    int errors = 0;

    // Model: per instance, whether a transaction runs, its kind, its cycle offset.
    bit            m_act [2];
    bit            m_clear [2];
    bit            m_err [2];
    int            m_j [2];
    int            m_idx [2];
    logic [FB-1:0] m_data [2];

    always #5 UserCLK = ~UserCLK;

    frame_config_sequencer #(
        .FRAME_BITS_PER_ROW (FB), .MAX_FRAMES_PER_COL (F), .NUM_COLUMNS (N),
        .SETUP_CYCLES (1), .STROBE_CYCLES (2), .HOLD_CYCLES (1)
    ) u_dut0 (
        .UserCLK (UserCLK), .reset (reset), .req_valid (req_valid), .req_ready (req_ready[0]),
        .req_col (req_col), .req_frame (req_frame), .req_data (req_data),
        .clear_start (clear_start), .busy (busy[0]), .done (done[0]), .err (err[0]),
        .FrameData (frame_data[0]), .FrameStrobe (frame_strobe[0])
    );

    frame_config_sequencer #(
        .FRAME_BITS_PER_ROW (FB), .MAX_FRAMES_PER_COL (F), .NUM_COLUMNS (N),
        .SETUP_CYCLES (3), .STROBE_CYCLES (1), .HOLD_CYCLES (2)
    ) u_dut1 (
        .UserCLK (UserCLK), .reset (reset), .req_valid (req_valid), .req_ready (req_ready[1]),
        .req_col (req_col), .req_frame (req_frame), .req_data (req_data),
        .clear_start (clear_start), .busy (busy[1]), .done (done[1]), .err (err[1]),
        .FrameData (frame_data[1]), .FrameStrobe (frame_strobe[1])
    );

    task automatic chk(input string tag, input int inst, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int            p;
            int            slot;
            int            ph;
            logic [SW-1:0] e_strobe;
            logic          e_done;
            p        = SV[i] + TV[i] + HV[i];
            e_strobe = '0;
            e_done   = 1'b0;
            if (m_act[i]) begin
                slot = m_j[i] / p;
                ph   = m_j[i] % p;
                if (ph >= SV[i] && ph < SV[i] + TV[i])
                    e_strobe[m_clear[i] ? slot : m_idx[i]] = 1'b1;
                e_done = (ph == p - 1) && (!m_clear[i] || slot == N * F - 1);
            end
            chk("busy",      i, SW'(busy[i]),       SW'(m_act[i]));
            chk("req_ready", i, SW'(req_ready[i]),  SW'(!m_act[i] && !clear_start));
            chk("done",      i, SW'(done[i]),       SW'(e_done));
            chk("err",       i, SW'(err[i]),        SW'(m_err[i]));
            chk("FrameData", i, SW'(frame_data[i]), SW'(m_data[i]));
            chk("FrameStrobe", i, frame_strobe[i],  e_strobe);
            chk("strobe_onehot0", i, SW'($onehot0(frame_strobe[i])), SW'(1'b1));
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int p;
            int total;
            bit err_next;
            p        = SV[i] + TV[i] + HV[i];
            total    = m_clear[i] ? N * F * p : p;
            err_next = 1'b0;
            if (reset) begin
                m_act[i]   = 1'b0;
                m_clear[i] = 1'b0;
                m_data[i]  = '0;
            end else if (m_act[i]) begin
                m_j[i]++;
                if (m_j[i] >= total) begin
                    m_act[i]   = 1'b0;
                    m_clear[i] = 1'b0;
                end
            end else if (clear_start) begin
                m_act[i]   = 1'b1;
                m_clear[i] = 1'b1;
                m_j[i]     = 0;
                m_data[i]  = '0;
            end else if (req_valid) begin
                if (int'(req_frame) >= F || int'(req_col) >= N) begin
                    err_next = 1'b1;
                end else begin
                    m_act[i]   = 1'b1;
                    m_clear[i] = 1'b0;
                    m_j[i]     = 0;
                    m_idx[i]   = int'(req_col) * F + int'(req_frame);
                    m_data[i]  = req_data;
                end
            end
            m_err[i] = err_next;
        end
    endtask

    task automatic cycle();
        #1;
        check_all();
        @(posedge UserCLK);
        model_edge();
        @(negedge UserCLK);
    endtask

    task automatic set_req(input bit v, input int col, input int frame, input logic [FB-1:0] data);
        req_valid = v;
        req_col   = 2'(col);
        req_frame = 5'(frame);
        req_data  = data;
    endtask

    initial begin
        reset       = 1'b1;
        clear_start = 1'b0;
        set_req(1'b0, 0, 0, '0);
        repeat (2) begin
            @(posedge UserCLK);
            model_edge();
        end
        @(negedge UserCLK);
        reset = 1'b0;
        cycle();

        // Single in-range write: col 1, frame 3 -> strobe bit 23.
        set_req(1'b1, 1, 3, 32'hA5A5_0001);
        cycle();
        set_req(1'b0, 0, 0, '0);
        repeat (12) cycle();

        // Frame index out of range.
        set_req(1'b1, 0, 20, 32'h1234_5678);
        cycle();
        set_req(1'b0, 0, 0, '0);
        repeat (3) cycle();

        // Clear and request together: clear wins, full sweep follows.
        clear_start = 1'b1;
        set_req(1'b1, 2, 5, 32'hDEAD_BEEF);
        cycle();
        clear_start = 1'b0;
        set_req(1'b0, 0, 0, '0);
        repeat (490) cycle();

        // Reset while the default instance is strobing, then a fresh write.
        set_req(1'b1, 2, 7, 32'hCAFE_F00D);
        cycle();
        set_req(1'b0, 0, 0, '0);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (2) cycle();
        set_req(1'b1, 3, 19, 32'h0BAD_C0DE);
        cycle();
        set_req(1'b0, 0, 0, '0);
        repeat (10) cycle();

        // Back-to-back writes with req_valid held high.
        repeat (40) begin
            set_req(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 19)), $urandom);
            cycle();
        end
        set_req(1'b0, 0, 0, '0);
        repeat (10) cycle();

        // Random mix of writes, bad indices, clears and resets.
        repeat (600) begin
            set_req($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 23)), $urandom);
            clear_start = ($urandom_range(0, 149) == 0);
            reset       = ($urandom_range(0, 249) == 0);
            cycle();
        end
        reset       = 1'b0;
        clear_start = 1'b0;
        set_req(1'b0, 0, 0, '0);
        repeat (5) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
